// File: rtl/ms_alarm_pkg.sv
// Shared types and helpers for the millisecond alarm unit.
package ms_alarm_pkg;

  localparam int unsigned MS_W = 32;
  localparam logic [MS_W-1:0] MAX_DELAY = 32'h7FFF_FFFF;

  typedef enum logic {
    IDLE,
    ARMED
  } ch_state_t;

  // Wrap-safe: the target is reached once (ms - target) is non-negative as a signed value.
  function automatic logic is_expired(input logic [MS_W-1:0] ms,
                                      input logic [MS_W-1:0] target);
    logic [MS_W-1:0] diff;
    diff = ms - target;
    return ~diff[MS_W-1];
  endfunction

endpackage

// File: rtl/ms_alarm_ch.sv
// One alarm channel: target/period/mode registers, IDLE/ARMED state, pend and overrun flags.
// ALARM_REMAIN_EN exposes the target and due status for the remaining-time readout.
module ms_alarm_ch
  import ms_alarm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [MS_W-1:0] ms,
  input  logic            wr,
  input  logic            cancel,
  input  logic [MS_W-1:0] delay,
  input  logic            periodic,
  input  logic            ack,
  output logic            active,
  output logic            pend,
  output logic            overrun
`ifdef ALARM_REMAIN_EN
  ,
  output logic [MS_W-1:0] target,
  output logic            due
`endif
);

  ch_state_t       state, state_next;
  logic [MS_W-1:0] target_q;
  logic [MS_W-1:0] period;
  logic [MS_W-1:0] dly;
  logic            mode;
  logic            expiry;
  logic            fire;

  assign dly    = delay[MS_W-1] ? MAX_DELAY : delay;
  assign expiry = (state == ARMED) && is_expired(ms, target_q);
  assign active = (state == ARMED);

`ifdef ALARM_REMAIN_EN
  assign target = target_q;
  assign due    = expiry;
`endif

  // Priority: cancel over re-arm over expiry; a re-arm in the expiry cycle swallows the event.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    if (cancel) begin
      state_next = IDLE;
    end else if (wr) begin
      state_next = ARMED;
    end else if (expiry) begin
      fire = 1'b1;
      if (!mode) state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      period   <= '0;
      mode     <= 1'b0;
      pend     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (!cancel && wr) begin
        target_q <= ms + dly;
        period   <= dly;
        mode     <= periodic && (delay != '0);
      end else if (fire && mode) begin
        target_q <= target_q + period;
      end

      if (fire) begin
        pend    <= 1'b1;
        overrun <= ~ack & (overrun | pend);
      end else if (ack) begin
        pend    <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ms_alarm.sv
// Multi-channel millisecond alarm: channel decode, interrupt reduction and optional
// remaining-time readout (rem_o, present only when ALARM_REMAIN_EN is defined).
module ms_alarm
  import ms_alarm_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [MS_W-1:0] ms_i,
  input  logic            wr_i,
  input  logic            cancel_i,
  input  logic [CH_W-1:0] ch_i,
  input  logic [MS_W-1:0] delay_i,
  input  logic            periodic_i,
  input  logic [NCH-1:0]  ack_i,
  output logic [NCH-1:0]  active_o,
  output logic [NCH-1:0]  pend_o,
  output logic [NCH-1:0]  overrun_o,
  output logic            irq_o
`ifdef ALARM_REMAIN_EN
  ,
  output logic [MS_W-1:0] rem_o
`endif
);

`ifdef ALARM_REMAIN_EN
  logic [MS_W-1:0] target [NCH];
  logic [NCH-1:0]  due;
`endif

  // Out-of-range selects match no channel and are therefore ignored.
  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic sel;
    assign sel = (ch_i == CH_W'(n));

    ms_alarm_ch u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .ms       (ms_i),
      .wr       (wr_i && sel),
      .cancel   (cancel_i && sel),
      .delay    (delay_i),
      .periodic (periodic_i),
      .ack      (ack_i[n]),
      .active   (active_o[n]),
      .pend     (pend_o[n]),
      .overrun  (overrun_o[n])
`ifdef ALARM_REMAIN_EN
      ,
      .target   (target[n]),
      .due      (due[n])
`endif
    );
  end

  assign irq_o = |pend_o;

`ifdef ALARM_REMAIN_EN
  always_comb begin
    rem_o = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_i == CH_W'(i) && active_o[i] && !due[i]) rem_o = target[i] - ms_i;
    end
  end
`endif

endmodule

// File: tb/tb_ms_alarm.sv
// Directed, table-driven bench for ms_alarm (NCH=4); rem_o checks only with ALARM_REMAIN_EN.
module tb_ms_alarm;

  logic        clk = 1'b0;
  logic        rst_i, wr_i, cancel_i, periodic_i, irq_o;
  logic [31:0] ms_i, delay_i;
  logic [1:0]  ch_i;
  logic [3:0]  ack_i, active_o, pend_o, overrun_o;
`ifdef ALARM_REMAIN_EN
  logic [31:0] rem_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ms_alarm #(.NCH(4), .CH_W(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ms_i       (ms_i),
    .wr_i       (wr_i),
    .cancel_i   (cancel_i),
    .ch_i       (ch_i),
    .delay_i    (delay_i),
    .periodic_i (periodic_i),
    .ack_i      (ack_i),
    .active_o   (active_o),
    .pend_o     (pend_o),
    .overrun_o  (overrun_o),
    .irq_o      (irq_o)
`ifdef ALARM_REMAIN_EN
    ,
    .rem_o      (rem_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] ms;
    logic        wr;
    logic        cancel;
    logic [1:0]  ch;
    logic [31:0] delay;
    logic        periodic;
    logic [3:0]  ack;
    logic [3:0]  act;
    logic [3:0]  pend;
    logic [3:0]  ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [31:0] ms, input logic wr,
                     input logic cancel, input logic [1:0] ch, input logic [31:0] delay,
                     input logic periodic, input logic [3:0] ack,
                     input logic [3:0] act, input logic [3:0] pend, input logic [3:0] ovr);
    vec_t v;
    v.rst = rst; v.ms = ms; v.wr = wr; v.cancel = cancel; v.ch = ch;
    v.delay = delay; v.periodic = periodic; v.ack = ack;
    v.act = act; v.pend = pend; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; wr_i = 1'b0; cancel_i = 1'b0; ch_i = '0;
    delay_i = '0; periodic_i = 1'b0; ack_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fires;
    logic saw_ovr;

    idle_inputs();
    ms_i = '0;

    //  rst ms            wr cn ch delay          per ack      act      pend     ovr
    add(1, 32'd0,         0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // one-shot ch0
    add(0, 32'd100,       1, 0, 0, 32'd5,         0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd104,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd105,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(0, 32'd106,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(0, 32'd106,       0, 0, 0, 32'd0,         0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // wrap on ch2
    add(0, 32'hFFFF_FFFE, 1, 0, 2, 32'd4,         0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 32'hFFFF_FFFF, 0, 0, 0, 32'd0,         0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 32'd0,         0, 0, 0, 32'd0,         0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 32'd1,         0, 0, 0, 32'd0,         0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 32'd2,         0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    add(0, 32'd3,         0, 0, 0, 32'd0,         0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    // periodic ch1, period 3
    add(0, 32'd10,        1, 0, 1, 32'd3,         1, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(0, 32'd13,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    add(0, 32'd13,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    add(0, 32'd16,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
    add(0, 32'd17,        0, 0, 0, 32'd0,         0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    add(0, 32'd19,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    // ack and expiry together (target 22), then cancel with ack
    add(0, 32'd22,        0, 0, 0, 32'd0,         0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    add(0, 32'd22,        0, 1, 1, 32'd0,         0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    // wr in the expiry cycle: new target 37 replaces 32
    add(0, 32'd30,        1, 0, 0, 32'd2,         0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd32,        1, 0, 0, 32'd5,         0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd33,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd37,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(0, 32'd37,        0, 0, 0, 32'd0,         0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // wr and cancel together
    add(0, 32'd40,        1, 1, 3, 32'd1,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 32'd41,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // cancel ch3 before target 60
    add(0, 32'd50,        1, 0, 3, 32'd10,        0, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add(0, 32'd55,        0, 1, 3, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 32'd60,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // delay 0 periodic is forced one-shot
    add(0, 32'd70,        1, 0, 0, 32'd0,         1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd70,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(0, 32'd71,        0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(0, 32'd71,        0, 0, 0, 32'd0,         0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // oversize delay clamps to 7FFF_FFFF
    add(0, 32'd0,         1, 0, 1, 32'h9000_0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(0, 32'h7FFF_FFFE, 0, 0, 0, 32'd0,         0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(0, 32'h7FFF_FFFF, 0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    add(0, 32'h8000_0000, 0, 0, 0, 32'd0,         0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    // reset with two armed and one pending
    add(0, 32'd200,       1, 0, 0, 32'd50,        0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 32'd200,       1, 0, 1, 32'd60,        1, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    add(0, 32'd200,       1, 0, 2, 32'd0,         0, 4'b0000, 4'b0111, 4'b0000, 4'b0000);
    add(0, 32'd201,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0011, 4'b0100, 4'b0000);
    add(1, 32'd201,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 32'd260,       0, 0, 0, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    #1;
    foreach (vecs[i]) begin
      rst_i = vecs[i].rst; ms_i = vecs[i].ms; wr_i = vecs[i].wr;
      cancel_i = vecs[i].cancel; ch_i = vecs[i].ch; delay_i = vecs[i].delay;
      periodic_i = vecs[i].periodic; ack_i = vecs[i].ack;
      step();
      check($sformatf("v%0d active", i), {28'd0, active_o}, {28'd0, vecs[i].act});
      check($sformatf("v%0d pend", i), {28'd0, pend_o}, {28'd0, vecs[i].pend});
      check($sformatf("v%0d overrun", i), {28'd0, overrun_o}, {28'd0, vecs[i].ovr});
      check($sformatf("v%0d irq", i), {31'd0, irq_o}, {31'd0, |vecs[i].pend});
    end

    // Free-running count: periodic ch3 every 3 ms from 300, acked the step after each fire.
    idle_inputs();
    ms_i = 32'd300; wr_i = 1'b1; ch_i = 2'd3; delay_i = 32'd3; periodic_i = 1'b1;
    step();
    idle_inputs();
    fires = 0;
    saw_ovr = 1'b0;
    for (int unsigned m = 301; m <= 312; m++) begin
      ack_i = pend_o[3] ? 4'b1000 : 4'b0000;
      ms_i = m;
      step();
      if (pend_o[3]) fires++;
      if (overrun_o[3]) saw_ovr = 1'b1;
    end
    check("run fires", fires, 32'd4);
    check("run overrun", {31'd0, saw_ovr}, 32'd0);
    check("run still armed", {28'd0, active_o}, 32'h8);
    ack_i = 4'b1000; cancel_i = 1'b1; ch_i = 2'd3;
    step();
    idle_inputs();

`ifdef ALARM_REMAIN_EN
    ms_i = 32'd100; wr_i = 1'b1; ch_i = 2'd0; delay_i = 32'd7;
    step();
    idle_inputs();
    ms_i = 32'd100; ch_i = 2'd0;
    #1 check("rem at 100", rem_o, 32'd7);
    ms_i = 32'd103;
    #1 check("rem at 103", rem_o, 32'd4);
    ch_i = 2'd1;
    #1 check("rem idle ch", rem_o, 32'd0);
    ch_i = 2'd0; ms_i = 32'd107;
    #1 check("rem at expiry", rem_o, 32'd0);
    cancel_i = 1'b1;
    step();
    idle_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_alarm.md
Name: ms_alarm

Overview:
- Multi-channel millisecond alarm unit; consumes the free-running 32-bit millisecond count from the ms timer stage.
- Each channel is armed with a delay in ms and raises a pending flag when the count reaches its target.
- Supports one-shot or periodic operation and drives one interrupt line to the soft core.
- Backs delay(), timeout and periodic-task services.

Parameters:
- NCH, 4, number of alarm channels (1..8).
- CH_W, 2, channel select width; must be >= clog2(NCH), minimum 1.

Ports:
- clk_i  in  1  system clock, same domain as the ms timer
- rst_i  in  1  synchronous, active-high reset
- ms_i  in  32  current millisecond count from the ms timer stage
- wr_i  in  1  arm strobe for channel ch_i
- cancel_i  in  1  disarm strobe for channel ch_i
- ch_i  in  CH_W  channel select for wr_i/cancel_i (and rem_o when enabled)
- delay_i  in  32  delay/period in ms, sampled on wr_i
- periodic_i  in  1  sampled on wr_i; 1 = periodic, 0 = one-shot
- ack_i  in  NCH  per-channel pending clear mask
- active_o  out  NCH  channel armed
- pend_o  out  NCH  alarm pending
- overrun_o  out  NCH  sticky: channel expired again while still pending
- irq_o  out  1  OR of pend_o
- rem_o  out  32  remaining ms for ch_i (only with ALARM_REMAIN_EN)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: active_o, pend_o, overrun_o, irq_o, rem_o all 0. Per-channel target, period and mode registers cleared.
- Channel states: IDLE, ARMED.
- Pending flags: pend and overrun are independent flags, not states.
- Arming: wr_i with ch_i < NCH arms the channel:
  - target <= ms_i + d, where d = min(delay_i, 32'h7FFF_FFFF); addition is modulo 2^32.
  - period <= d; mode <= periodic_i; state <= ARMED.
  - If delay_i = 0 and periodic_i = 1, the channel is forced to one-shot.
- Out-of-range select: wr_i or cancel_i with ch_i >= NCH is ignored.
- Expiry test (wrap-safe): the channel is expired when bit 31 of (ms_i - target) is 0. The test is evaluated every cycle while ARMED.
- Expiry action (registered; pend_o rises 1 cycle after the ms_i value that satisfies the test):
  - One-shot: state -> IDLE, pend set.
  - Periodic: target <= target + period, stays ARMED, pend set.
  - Each expiry sets pend exactly once; it does not refire while ms_i holds its value.
- Overrun: an expiry while pend is already 1 sets overrun.
- ack_i[n] clears pend[n] and overrun[n].
- Simultaneous ack and expiry on one channel: pend = 1, overrun = 0. The new event wins.
- Simultaneous wr and expiry on one channel: the re-arm wins; no pend set that cycle.
- Simultaneous wr and cancel: cancel wins; channel -> IDLE.
- cancel_i: state -> IDLE. pend and overrun are unaffected.
- irq_o: combinational OR of the pend registers; no path from inputs.
- Timer reset mid-operation: no coupling to the timer stage. If ms_i jumps backwards, armed channels wait until ms_i catches up to target; software re-arms.
- Reset mid-operation: all channels return to IDLE and all flags clear on the next edge.

Optional Feature:
- Macro: ALARM_REMAIN_EN.
- Defined: rem_o = target - ms_i (combinational) for channel ch_i when that channel is ARMED and not yet expired. Otherwise rem_o = 0. rem_o is 0 when ch_i >= NCH.
- Not defined: rem_o port is absent; no subtractor or output mux is built.

Decomposition:
- Package ms_alarm_pkg contents:
  - MS_W = 32
  - MAX_DELAY = 32'h7FFF_FFFF
  - channel state typedef (IDLE, ARMED)
  - function for the wrap-safe expiry test
- Sub-module ms_alarm_ch, one per channel, generated NCH times. It holds the target, period, mode, state, pend and overrun registers.
- Top-level ms_alarm handles:
  - ch_i decode
  - irq_o reduction
  - rem_o mux (when enabled)

Test Plan:
- One-shot: ms_i=100, wr ch0 delay 5. Then:
  - pend_o[0] rises the cycle after ms_i=105; active_o[0] falls; irq_o=1.
  - ack_i=4'b0001 clears pend_o[0] and irq_o.
- Wrap: ms_i=32'hFFFF_FFFE, wr ch2 delay 4 -> no pend at FFFF_FFFF/0/1; pend_o[2] after ms_i=2.
- Periodic ch1, delay 3 at ms_i=10:
  - Fires at 13, 16 and 19, once each.
  - With no ack, overrun_o[1]=1 after 16.
  - ack clears both flags; the channel stays armed.
- Collisions:
  - ack and expiry same cycle -> pend=1, overrun=0.
  - wr and expiry same cycle -> no pend, new target in use.
  - wr and cancel same cycle -> IDLE.
- Cancel and reset:
  - cancel ch3 at ms 50 (target 60) -> no pend at 60.
  - rst_i asserted with 2 channels armed and 1 pending -> all outputs 0 next cycle.
- Boundaries:
  - delay 0 -> pend the cycle after wr.
  - delay 32'h9000_0000 -> clamped to 32'h7FFF_FFFF.
  - with ALARM_REMAIN_EN, rem_o = 7 for target 107 at ms_i=100.
